// File: rtl/adder_pkg.sv
// Shared definitions for the shift-and-add multiplier adder.
// Holds the default operand width and a reference sum helper for benches.
package adder_pkg;

   localparam int DEFAULT_N = 4;

   // Width-agnostic reference: callers slice the low n+1 bits they need.
   function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

endpackage

// File: rtl/adder_full_adder.sv
// Single-bit full adder cell: (a, b, cin) -> (s, cout).
// Used as the ripple stage and, with cin tied low, as a propagate/generate cell.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/adder.sv
// n-bit unsigned adder {C,Sum} = A + M with a one-cycle registered copy.
// Define ADDER_CARRY_LOOKAHEAD_EN for 4-bit lookahead groups instead of ripple carry.
module adder
   import adder_pkg::*;
#(
   parameter int n = DEFAULT_N
) (
   input  logic         clock,
   input  logic         n_reset,
   input  logic [n-1:0] A,
   input  logic [n-1:0] M,
   output logic [n-1:0] Sum,
   output logic         C,
   output logic [n-1:0] Sum_q,
   output logic         C_q
);

`ifdef ADDER_CARRY_LOOKAHEAD_EN

   localparam int NG = (n + 3) / 4;

   logic [n-1:0] p;
   logic [n-1:0] g;
   logic [n:0]   carry;

   // With cin low the cell's sum is the bit propagate and its carry the bit generate.
   for (genvar gi = 0; gi < n; gi++) begin : g_pg
      full_adder u_pg (
         .a    (A[gi]),
         .b    (M[gi]),
         .cin  (1'b0),
         .s    (p[gi]),
         .cout (g[gi])
      );
   end

   // Each carry inside a group is a flat sum-of-products of that group's g/p and
   // the group carry-in; the group carry-out then feeds the next group.
   always_comb begin
      logic acc;
      logic prod;
      acc   = 1'b0;
      prod  = 1'b0;
      carry = '0;
      for (int grp = 0; grp < NG; grp++) begin
         for (int j = 1; j <= 4; j++) begin
            if (grp * 4 + j <= n) begin
               acc = 1'b0;
               for (int m = grp * 4; m < grp * 4 + j; m++) begin
                  prod = g[m];
                  for (int k = m + 1; k < grp * 4 + j; k++) begin
                     prod = prod & p[k];
                  end
                  acc = acc | prod;
               end
               prod = carry[grp * 4];
               for (int k = grp * 4; k < grp * 4 + j; k++) begin
                  prod = prod & p[k];
               end
               carry[grp * 4 + j] = acc | prod;
            end
         end
      end
   end

   assign Sum = p ^ carry[n-1:0];
   assign C   = carry[n];

`else

   for (genvar gi = 0; gi < n; gi++) begin : g_rip
      logic cin_w;
      logic cout_w;
      if (gi == 0) begin : g_first
         assign cin_w = 1'b0;
      end else begin : g_link
         assign cin_w = g_rip[gi-1].cout_w;
      end
      full_adder u_fa (
         .a    (A[gi]),
         .b    (M[gi]),
         .cin  (cin_w),
         .s    (Sum[gi]),
         .cout (cout_w)
      );
   end

   assign C = g_rip[n-1].cout_w;

`endif

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         Sum_q <= '0;
         C_q   <= 1'b0;
      end else begin
         Sum_q <= Sum;
         C_q   <= C;
      end
   end

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder at widths 1, 4, 8 and 16 against an arithmetic model.
module tb_adder;

   logic clock;
   logic n_reset;

   logic [0:0]  a1, m1, sum1, sumq1;
   logic [3:0]  a4, m4, sum4, sumq4;
   logic [7:0]  a8, m8, sum8, sumq8;
   logic [15:0] a16, m16, sum16, sumq16;
   logic        c1, cq1, c4, cq4, c8, cq8, c16, cq16;

   int total = 0;
   int bad   = 0;

   adder #(.n(1)) u_add1 (
      .clock(clock), .n_reset(n_reset), .A(a1), .M(m1),
      .Sum(sum1), .C(c1), .Sum_q(sumq1), .C_q(cq1)
   );
   adder #(.n(4)) u_add4 (
      .clock(clock), .n_reset(n_reset), .A(a4), .M(m4),
      .Sum(sum4), .C(c4), .Sum_q(sumq4), .C_q(cq4)
   );
   adder #(.n(8)) u_add8 (
      .clock(clock), .n_reset(n_reset), .A(a8), .M(m8),
      .Sum(sum8), .C(c8), .Sum_q(sumq8), .C_q(cq8)
   );
   adder #(.n(16)) u_add16 (
      .clock(clock), .n_reset(n_reset), .A(a16), .M(m16),
      .Sum(sum16), .C(c16), .Sum_q(sumq16), .C_q(cq16)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected {carry,sum} from the arithmetic rules: wrap modulo 2^w, carry when sum >= 2^w.
   function automatic logic [63:0] model_add(input longint a, input longint b, input int w);
      longint total_v;
      longint lim;
      longint s;
      longint c;
      total_v = a + b;
      lim     = longint'(1) << w;
      s       = total_v % lim;
      c       = (total_v >= lim) ? 1 : 0;
      return 64'((c << w) | s);
   endfunction

   typedef struct { int a; int m; int s; int c; } bnd_t;
   bnd_t bnd[5];

   initial begin
      n_reset = 1'b0;
      a1 = '0; m1 = '0; a4 = 4'd3; m4 = 4'd4;
      a8 = '0; m8 = '0; a16 = '0; m16 = '0;

      #3;
      check_val("rst_sumq4", 64'(sumq4), 64'd0);
      check_val("rst_cq4", 64'(cq4), 64'd0);
      check_val("rst_comb4", 64'({c4, sum4}), model_add(3, 4, 4));
      check_val("rst_sumq16", 64'({cq16, sumq16}), 64'd0);

      @(negedge clock);
      n_reset = 1'b1;

      for (int a = 0; a < 16; a++) begin
         for (int m = 0; m < 16; m++) begin
            a4 = 4'(a); m4 = 4'(m);
            #2;
            check_val("exh4", 64'({c4, sum4}), model_add(a, m, 4));
         end
      end

      bnd[0] = '{0, 0, 0, 0};
      bnd[1] = '{15, 1, 0, 1};
      bnd[2] = '{8, 8, 0, 1};
      bnd[3] = '{7, 8, 15, 0};
      bnd[4] = '{15, 15, 14, 1};
      foreach (bnd[i]) begin
         a4 = 4'(bnd[i].a); m4 = 4'(bnd[i].m);
         #2;
         check_val("bnd4_sum", 64'(sum4), 64'(bnd[i].s));
         check_val("bnd4_c", 64'(c4), 64'(bnd[i].c));
      end

      for (int a = 0; a < 2; a++) begin
         for (int m = 0; m < 2; m++) begin
            a1 = 1'(a); m1 = 1'(m);
            #2;
            check_val("exh1", 64'({c1, sum1}), model_add(a, m, 1));
         end
      end

      for (int i = 0; i < 10000; i++) begin
         a8 = 8'($urandom); m8 = 8'($urandom);
         a16 = 16'($urandom); m16 = 16'($urandom);
         #2;
         check_val("rnd8", 64'({c8, sum8}), model_add(longint'(a8), longint'(m8), 8));
         check_val("rnd16", 64'({c16, sum16}), model_add(longint'(a16), longint'(m16), 16));
      end

      a16 = 16'hFFFF; m16 = 16'd1;
      #2;
      check_val("ones16_sum", 64'(sum16), 64'd0);
      check_val("ones16_c", 64'(c16), 64'd1);

      // Registered path, fixed vectors
      @(negedge clock);
      a4 = 4'd5; m4 = 4'd9;
      @(posedge clock); #1;
      check_val("reg_sumq_a", 64'(sumq4), 64'd14);
      check_val("reg_cq_a", 64'(cq4), 64'd0);
      @(negedge clock);
      a4 = 4'd12; m4 = 4'd6;
      @(posedge clock); #1;
      check_val("reg_sumq_b", 64'(sumq4), 64'd2);
      check_val("reg_cq_b", 64'(cq4), 64'd1);

      // Registered path, random
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         a8 = 8'($urandom); m8 = 8'($urandom);
         a16 = 16'($urandom); m16 = 16'($urandom);
         @(posedge clock); #1;
         check_val("regq8", 64'({cq8, sumq8}), model_add(longint'(a8), longint'(m8), 8));
         check_val("regq16", 64'({cq16, sumq16}), model_add(longint'(a16), longint'(m16), 16));
      end

      // Async reset between edges
      @(negedge clock);
      a4 = 4'd5; m4 = 4'd9;
      @(posedge clock); #1;
      check_val("pre_rst_sumq", 64'(sumq4), 64'd14);
      #1;
      n_reset = 1'b0;
      #1;
      check_val("arst_sumq", 64'(sumq4), 64'd0);
      check_val("arst_cq", 64'(cq4), 64'd0);
      check_val("arst_comb", 64'({c4, sum4}), model_add(5, 9, 4));
      a4 = 4'd3; m4 = 4'd15;
      #1;
      check_val("arst_comb2", 64'({c4, sum4}), model_add(3, 15, 4));
      @(negedge clock);
      n_reset = 1'b1;
      #1;
      check_val("rel_hold_sumq", 64'({cq4, sumq4}), 64'd0);
      @(posedge clock); #1;
      check_val("rel_sumq", 64'(sumq4), 64'd2);
      check_val("rel_cq", 64'(cq4), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
